// File: rtl/mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
// mac_tx_arbiter : round-robin, whole-frame arbiter for the MAC TX byte path,
//                  with zero padding to MIN_LEN and a forced inter-frame gap.
// Revision       : 1.0
// ============================================================================
module mac_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] in_data,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [NUM_REQ-1:0]   in_last,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CNT_W = $clog2(MIN_LEN + 1);
  localparam int c_IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_PAD  = 2'd2,
    S_IFG  = 2'd3
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant,    w_grant_nxt;
  logic [c_IDX_W-1:0]   r_gidx,     w_gidx_nxt;
  logic [c_IDX_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
  logic [c_CNT_W-1:0]   r_byte_cnt, w_byte_cnt_nxt;
  logic [c_IFG_W-1:0]   r_ifg_cnt,  w_ifg_cnt_nxt;

  logic                 w_found;
  logic [c_IDX_W-1:0]   w_win;
  logic [c_IDX_W-1:0]   w_scan;
  logic                 w_hs;
  logic                 w_cnt_at_end;
  logic [c_CNT_W-1:0]   w_cnt_inc;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
    end
  end

  assign w_cnt_at_end = (int'(r_byte_cnt) + 1 >= MIN_LEN);
  assign w_cnt_inc    = (int'(r_byte_cnt) >= MIN_LEN) ? r_byte_cnt : r_byte_cnt + 1'b1;
  assign grant        = r_grant;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_gidx_nxt     = r_gidx;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_ifg_cnt_nxt  = r_ifg_cnt;
    w_hs           = 1'b0;
    in_ready       = '0;
    tx_data        = 8'h00;
    tx_valid       = 1'b0;
    tx_last        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt    = NUM_REQ'(1) << w_win;
          w_gidx_nxt     = w_win;
          w_rr_ptr_nxt   = c_IDX_W'((int'(w_win) + 1) % NUM_REQ);
          w_byte_cnt_nxt = '0;
          w_state_nxt    = S_XFER;
        end
      end

      S_XFER: begin
        tx_data          = in_data[int'(r_gidx)*8 +: 8];
        tx_valid         = in_valid[r_gidx];
        tx_last          = in_valid[r_gidx] & in_last[r_gidx] & w_cnt_at_end;
        in_ready[r_gidx] = tx_ready;
        w_hs             = in_valid[r_gidx] & tx_ready;
        if (w_hs) begin
          w_byte_cnt_nxt = w_cnt_inc;
          if (in_last[r_gidx]) begin
            if (w_cnt_at_end) begin
              w_grant_nxt   = '0;
              w_ifg_cnt_nxt = c_IFG_W'(IFG_CYCLES - 1);
              w_state_nxt   = S_IFG;
            end else begin
              w_state_nxt   = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        tx_valid = 1'b1;
        tx_last  = w_cnt_at_end;
        w_hs     = tx_ready;
        if (w_hs) begin
          w_byte_cnt_nxt = w_cnt_inc;
          if (w_cnt_at_end) begin
            w_grant_nxt   = '0;
            w_ifg_cnt_nxt = c_IFG_W'(IFG_CYCLES - 1);
            w_state_nxt   = S_IFG;
          end
        end
      end

      S_IFG: begin
        // One cycle short here: the IDLE arbitration cycle completes the gap.
        if (r_ifg_cnt <= c_IFG_W'(1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ifg_cnt_nxt = r_ifg_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_ifg_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_ifg_cnt  <= w_ifg_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_arbiter.sv
`default_nettype none
// tb_mac_tx_arbiter: randomized frames from every source, checked by a scoreboard
// against a frame-level model of round-robin order, padding and gap timing.
module tb_mac_tx_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int MIN_LEN    = 60;
  localparam int IFG_CYCLES = 12;

  logic                 clk   = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req      = '0;
  logic [8*NUM_REQ-1:0] in_data  = '0;
  logic [NUM_REQ-1:0]   in_valid = '0;
  logic [NUM_REQ-1:0]   in_last  = '0;
  logic [NUM_REQ-1:0]   in_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_last;
  logic                 tx_ready = 1'b0;

  mac_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MIN_LEN   (MIN_LEN),
    .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .grant   (grant),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    int         len;
    logic [7:0] salt;
  } frame_t;

  frame_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // driver state
  logic       active   [NUM_REQ];
  int         cur_len  [NUM_REQ];
  int         cur_pos  [NUM_REQ];
  logic [7:0] cur_salt [NUM_REQ];
  logic       hs       [NUM_REQ];
  int         rand_left[NUM_REQ];
  int         dir0[$];
  int         dir1[$];
  int         p_start = 0, p_valid = 100, p_ready = 100, max_len = 80;
  logic       release_now = 1'b0;

  // monitor / reference model state
  logic       busy = 1'b0;
  logic       in_reset = 1'b1;
  int         cyc = 0;
  int         free_cycle = 0;
  int         m_rr = 0;
  int         idx = 0;
  frame_t     cur;
  logic [NUM_REQ-1:0] req_prev = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  function automatic logic [7:0] gen_byte(input logic [7:0] salt, input int pos);
    logic [31:0] v;
    v = 32'(salt) * 3 + 32'(pos) * 37;
    return v[7:0];
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic work_pending();
    logic w;
    w = (dir0.size() != 0) || (dir1.size() != 0) || busy || (exp_q.size() != 0);
    for (int s = 0; s < NUM_REQ; s++) w = w || active[s] || (rand_left[s] != 0);
    return w;
  endfunction

  // One clock of source/sink stimulus, applied on the falling edge.
  task automatic drive_cycle();
    int     len;
    frame_t f;
    @(negedge clk);
    if (release_now) begin
      reset       = 1'b0;
      release_now = 1'b0;
    end
    for (int s = 0; s < NUM_REQ; s++) begin
      if (hs[s]) begin
        in_valid[s] = 1'b0;
        if (cur_pos[s] == cur_len[s] - 1) begin
          active[s]  = 1'b0;
          req[s]     = 1'b0;
          in_last[s] = 1'b0;
        end else begin
          cur_pos[s]++;
        end
      end
    end
    for (int s = 0; s < NUM_REQ; s++) begin
      len = 0;
      if (!active[s] && !reset) begin
        if (s == 0 && dir0.size() != 0)      len = dir0.pop_front();
        else if (s == 1 && dir1.size() != 0) len = dir1.pop_front();
        else if (rand_left[s] != 0 && $urandom_range(0, 99) < p_start) begin
          len = $urandom_range(1, max_len);
          rand_left[s]--;
        end
      end
      if (len > 0) begin
        active[s]   = 1'b1;
        cur_len[s]  = len;
        cur_pos[s]  = 0;
        cur_salt[s] = 8'($urandom);
        req[s]      = 1'b1;
        f.src = s; f.len = len; f.salt = cur_salt[s];
        exp_q.push_back(f);
      end
    end
    for (int s = 0; s < NUM_REQ; s++) begin
      if (active[s] && !in_valid[s] && $urandom_range(0, 99) < p_valid) begin
        in_valid[s]        = 1'b1;
        in_data[8*s +: 8]  = gen_byte(cur_salt[s], cur_pos[s]);
        in_last[s]         = (cur_pos[s] == cur_len[s] - 1);
      end
    end
    tx_ready = ($urandom_range(0, 99) < p_ready);
    #1;
    for (int s = 0; s < NUM_REQ; s++) hs[s] = in_valid[s] & in_ready[s];
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (work_pending() && n < limit) begin
      drive_cycle();
      n++;
    end
    chk(name, 32'(n < limit), 32'd1);
    repeat (IFG_CYCLES + 3) drive_cycle();
  endtask

  // Monitor: reference model of arbitration, padding and gap, plus scoreboard pops.
  initial begin
    int     w;
    int     total;
    logic   found;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (reset) begin
        chk("reset_outputs", 32'({grant, in_ready, tx_valid, tx_last, tx_data}), 32'd0);
        busy       = 1'b0;
        m_rr       = 0;
        prev_stall = 1'b0;
        in_reset   = 1'b1;
      end else begin
        if (in_reset) begin
          in_reset   = 1'b0;
          free_cycle = cyc;
        end
        if (prev_stall)
          chk("stall_hold", 32'({tx_valid, tx_last, tx_data}), 32'({1'b1, prev_last, prev_data}));
        if (!busy) begin
          if (cyc - 1 >= free_cycle && req_prev != '0) begin
            w = rr_pick(req_prev, m_rr);
            chk("grant_winner", 32'(grant), 32'(1) << w);
            m_rr  = (w + 1) % NUM_REQ;
            busy  = 1'b1;
            idx   = 0;
            found = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (!found && exp_q[i].src == w) begin
                cur   = exp_q[i];
                exp_q.delete(i);
                found = 1'b1;
              end
            end
            chk("frame_known", 32'(found), 32'd1);
            if (!found) busy = 1'b0;
          end else begin
            chk("idle_quiet", 32'({grant, tx_valid}), 32'd0);
          end
        end
        if (busy) begin
          chk("grant_hold", 32'(grant), 32'(1) << cur.src);
          if (idx >= cur.len) chk("pad_in_ready", 32'(in_ready), 32'd0);
          else                chk("xfer_in_ready", 32'(in_ready), 32'(tx_ready) << cur.src);
          if (tx_valid && tx_ready) begin
            total = (cur.len > MIN_LEN) ? cur.len : MIN_LEN;
            eb    = (idx < cur.len) ? gen_byte(cur.salt, idx) : 8'h00;
            chk("tx_byte", 32'({tx_last, tx_data}), 32'({(idx == total - 1), eb}));
            idx++;
            if (idx == total) begin
              busy       = 1'b0;
              free_cycle = cyc + IFG_CYCLES;
            end
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end
      req_prev = req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int n;
    for (int s = 0; s < NUM_REQ; s++) begin
      active[s] = 1'b0; cur_len[s] = 0; cur_pos[s] = 0;
      cur_salt[s] = 8'h00; hs[s] = 1'b0; rand_left[s] = 0;
    end
    repeat (3) drive_cycle();
    release_now = 1'b1;

    // Directed lengths on one source, sink always ready: 64, pad cases, exact MIN_LEN.
    dir0 = '{64, 10, 1, 60, 59, 61};
    p_ready = 100; p_valid = 100;
    wait_done("drain_directed", 3000);

    // Stalls mid-frame and mid-pad with a competing long frame.
    dir0 = '{10, 1};
    dir1 = '{70};
    p_ready = 50; p_valid = 70;
    wait_done("drain_stalled", 3000);

    // Reset in the middle of a frame, then requester 1 alone, then both.
    dir0 = '{64};
    p_ready = 100; p_valid = 100;
    n = 0;
    while (!(active[0] && cur_pos[0] >= 20) && n < 500) begin
      drive_cycle();
      n++;
    end
    chk("reach_byte20", 32'(n < 500), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_out", 32'({grant, in_ready, tx_valid, tx_last, tx_data}), 32'd0);
    for (int s = 0; s < NUM_REQ; s++) begin
      active[s] = 1'b0; hs[s] = 1'b0;
    end
    req = '0; in_valid = '0; in_last = '0;
    exp_q.delete();
    repeat (3) drive_cycle();
    dir1 = '{5};
    release_now = 1'b1;
    wait_done("drain_after_reset", 1000);
    dir0 = '{3};
    dir1 = '{4};
    wait_done("drain_rr_after_reset", 1000);

    // Continuous requests from both: grants must alternate.
    rand_left[0] = 4; rand_left[1] = 4;
    p_start = 100; max_len = 30;
    wait_done("drain_alternate", 4000);

    // Fully random traffic with sink back-pressure.
    rand_left[0] = 10; rand_left[1] = 10;
    p_start = 20; max_len = 90; p_ready = 65; p_valid = 75;
    wait_done("drain_random", 20000);

    chk("leftover_frames", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
